// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between instruction fetch (IF) and load/store (D).
// D has priority; a saturating starvation counter forces an IF grant after STARVE_LIMIT D wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_ack,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_d_req,
    input  logic                    i_d_we,
    input  logic [DATA_WIDTH/8-1:0] i_d_be,
    input  logic [ADDR_WIDTH-1:0]   i_d_addr,
    input  logic [DATA_WIDTH-1:0]   i_d_wdata,
    output logic                    o_d_ack,
    output logic [DATA_WIDTH-1:0]   o_d_rdata,
    output logic                    o_mem_en,
    output logic [DATA_WIDTH/8-1:0] o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_busy
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned SW   = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RDATA,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  sel_d_q, sel_d_d;
    logic                  wr_q, wr_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic                  if_ack_q, if_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  mem_en_q, mem_en_d;
    logic [BE_W-1:0]       mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  grant_if;
    logic                  starved;

    assign starved = (starve_q == SW'(STARVE_LIMIT));

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sel_d_d     = sel_d_q;
        wr_d        = wr_q;
        starve_d    = starve_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_if    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_if_req || i_d_req) begin
                    grant_if = i_if_req && (!i_d_req || starved);
                    sel_d_d  = !grant_if;
                    mem_en_d = 1'b1;
                    state_d  = S_ACCESS;
                    if (grant_if) begin
                        wr_d       = 1'b0;
                        mem_we_d   = '0;
                        mem_addr_d = i_if_addr;
                        starve_d   = '0;
                    end else begin
                        wr_d        = i_d_we;
                        mem_we_d    = i_d_we ? i_d_be : '0;
                        mem_addr_d  = i_d_addr;
                        mem_wdata_d = i_d_wdata;
                        if (i_if_req && !starved) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end
                end
            end
            S_ACCESS: begin
                if (wr_q) begin
                    state_d = S_DONE;
                    d_ack_d = 1'b1;
                end else begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                state_d = S_DONE;
                if (sel_d_q) begin
                    d_rdata_d = i_mem_rdata;
                    d_ack_d   = 1'b1;
                end else begin
                    if_rdata_d = i_mem_rdata;
                    if_ack_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= S_IDLE;
            sel_d_q     <= 1'b0;
            wr_q        <= 1'b0;
            starve_q    <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_d_q     <= sel_d_d;
            wr_q        <= wr_d;
            starve_q    <= starve_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign o_if_ack    = if_ack_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_ack     = d_ack_q;
    assign o_d_rdata   = d_rdata_q;
    assign o_mem_en    = mem_en_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: synchronous RAM model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized two-port traffic.
module tb_mem_port_arbiter;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned NWORD = 512;
    localparam int          LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [BW-1:0] d_be = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          o_if_ack, o_d_ack, o_mem_en, o_busy;
    logic [DW-1:0] o_if_rdata, o_d_rdata, o_mem_wdata;
    logic [BW-1:0] o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] ram     [NWORD];
    logic [DW-1:0] ref_mem [NWORD];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit if_done = 0, d_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter dut (
        .i_clk(clk), .i_arst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(o_busy)
    );

    // One-cycle-latency synchronous RAM with byte writes
    always @(posedge clk) begin
        if (o_mem_en) begin
            for (int b = 0; b < BW; b++)
                if (o_mem_we[b]) ram[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
            mem_rdata <= ram[o_mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: one access at a time, ack 2 (write) / 3 (read) cycles after grant
    bit            have_p = 0;
    int            p_grant, p_ack;
    bit            p_isd, p_wr;
    logic [AW-1:0] p_addr;
    logic [BW-1:0] p_we;
    logic [DW-1:0] p_wd, p_rdata;
    logic [DW-1:0] e_if_rd = '0, e_d_rd = '0;
    int            starve = 0;

    always @(negedge clk) begin
        bit e_en, e_busy, e_ifack, e_dack;
        if (rst) begin
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_en", 32'(o_mem_en), 0);
            chk("rst_acks", {30'b0, o_if_ack, o_d_ack}, 0);
            chk("rst_if_rdata", o_if_rdata, 0);
            chk("rst_d_rdata", o_d_rdata, 0);
            have_p = 0; starve = 0; e_if_rd = '0; e_d_rd = '0;
        end else begin
            if (have_p && cyc > p_ack) have_p = 0;
            e_en    = have_p && (cyc == p_grant + 1);
            e_busy  = have_p && (cyc > p_grant);
            e_ifack = have_p && (cyc == p_ack) && !p_isd;
            e_dack  = have_p && (cyc == p_ack) && p_isd;
            if (e_ifack) e_if_rd = p_rdata;
            if (e_dack && !p_wr) e_d_rd = p_rdata;
            chk("busy", 32'(o_busy), 32'(e_busy));
            chk("mem_en", 32'(o_mem_en), 32'(e_en));
            chk("if_ack", 32'(o_if_ack), 32'(e_ifack));
            chk("d_ack", 32'(o_d_ack), 32'(e_dack));
            chk("if_rdata", o_if_rdata, e_if_rd);
            chk("d_rdata", o_d_rdata, e_d_rd);
            if (e_en) begin
                chk("mem_addr", 32'(o_mem_addr), 32'(p_addr));
                chk("mem_we", 32'(o_mem_we), 32'(p_we));
                if (p_we != '0) chk("mem_wdata", o_mem_wdata, p_wd);
            end
            if (o_if_ack) if_done = 1;
            if (o_d_ack) d_done = 1;
            if (!have_p && (if_req || d_req)) begin
                have_p  = 1;
                p_grant = cyc;
                if (if_req && (!d_req || starve == LIMIT)) begin
                    p_isd = 0; p_wr = 0; p_addr = if_addr; p_we = '0; p_wd = '0;
                    starve = 0;
                end else begin
                    p_isd = 1; p_wr = d_we; p_addr = d_addr; p_wd = d_wdata;
                    p_we = d_we ? d_be : '0;
                    if (if_req && starve < LIMIT) starve = starve + 1;
                end
                p_rdata = ref_mem[p_addr];
                for (int b = 0; b < BW; b++)
                    if (p_we[b]) ref_mem[p_addr][8*b +: 8] = p_wd[8*b +: 8];
                p_ack = p_grant + (p_wr ? 2 : 3);
            end
        end
    end

    // Called just after a posedge; returns cycles from the first sampled cycle to the ack
    task automatic wait_ack(input bit isd, output int lat);
        lat = 0;
        @(negedge clk);
        while (!(isd ? o_d_ack : o_if_ack) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!(isd ? o_d_ack : o_if_ack)) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: no ack within 30 cycles (port %s)", isd ? "D" : "IF");
        end
    endtask

    task automatic d_xact(input logic we, input logic [BW-1:0] be, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int lat, output logic [DW-1:0] rd);
        d_we = we; d_be = be; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_ack(1'b1, lat);
        rd = o_d_rdata;
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    initial begin
        int            lat, t_prev, t_dack, extra_d, nack;
        logic [DW-1:0] rd;
        logic [9:0]    pat_got;
        logic [9:0]    pat_exp;

        for (int i = 0; i < NWORD; i++) begin
            ram[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset asserted while a D read sits in RDATA; held request is reissued
        d_we = 1'b0; d_be = '0; d_addr = 9'd5; d_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 0);
        chk("arst_d_ack", 32'(o_d_ack), 0);
        chk("arst_en", 32'(o_mem_en), 0);
        @(posedge clk); #1 rst = 1'b0;
        wait_ack(1'b1, lat);
        chk("reissue_lat", 32'(lat), 3);
        chk("reissue_rdata", o_d_rdata, 32'hC0DE_0005);
        @(posedge clk); #1 d_req = 1'b0;

        // Full-word write to the mailbox, checking the strobe cycle and write latency
        d_we = 1'b1; d_be = 4'hF; d_addr = 9'd320; d_wdata = 32'd1; d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wr320_en", 32'(o_mem_en), 1);
        chk("wr320_we", 32'(o_mem_we), 32'hF);
        chk("wr320_addr", 32'(o_mem_addr), 320);
        @(negedge clk);
        chk("wr320_ack_lat2", 32'(o_d_ack), 1);
        @(posedge clk); #1 d_req = 1'b0;
        d_xact(1'b0, '0, 9'd320, '0, lat, rd);
        chk("rd320_lat", 32'(lat), 3);
        chk("rd320_data", rd, 32'd1);

        // Byte-lane merge
        d_xact(1'b1, 4'hF, 9'd321, 32'h1122_3344, lat, rd);
        d_xact(1'b1, 4'b0010, 9'd321, 32'h0000_AB00, lat, rd);
        d_xact(1'b0, '0, 9'd321, '0, lat, rd);
        chk("byte_merge", rd, 32'h1122_AB44);

        // Zero byte-enable write still completes without changing memory
        d_xact(1'b1, 4'h0, 9'd321, 32'hFFFF_FFFF, lat, rd);
        chk("be0_lat", 32'(lat), 2);
        d_xact(1'b0, '0, 9'd321, '0, lat, rd);
        chk("be0_nochange", rd, 32'h1122_AB44);

        // IF alone, back-to-back reads of words 0..3
        t_prev = 0;
        if_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_addr = AW'(i);
            wait_ack(1'b0, lat);
            chk("if_seq_rdata", o_if_rdata, 32'hC0DE_0000 | 32'(i));
            if (i > 0) chk("if_seq_spacing", 32'(cyc - t_prev), 4);
            t_prev = cyc;
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        @(posedge clk); #1;

        // Both ports held: D,D,D,D,IF repeating (bit=1 means D granted)
        if_addr = 9'd0; d_we = 1'b0; d_addr = 9'd1;
        if_req = 1'b1; d_req = 1'b1;
        pat_exp = 10'b0111101111;
        pat_got = '0;
        nack = 0;
        for (int c = 0; c < 100 && nack < 10; c++) begin
            @(negedge clk);
            if (o_d_ack || o_if_ack) begin
                pat_got[nack] = o_d_ack;
                nack++;
            end
        end
        chk("starve_count", 32'(nack), 10);
        chk("starve_pattern", 32'(pat_got), 32'(pat_exp));
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // IF request first appears in the DONE cycle of a D write
        d_we = 1'b1; d_be = 4'hF; d_addr = 9'd200; d_wdata = 32'h5A5A_0001; d_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_addr = 9'd3; if_req = 1'b1;
        @(negedge clk);
        chk("done_d_ack", 32'(o_d_ack), 1);
        t_dack = cyc;
        @(posedge clk); #1 d_req = 1'b0;
        extra_d = 0;
        lat = 0;
        @(negedge clk);
        while (!o_if_ack && lat < 30) begin
            if (o_d_ack) extra_d++;
            @(negedge clk);
            lat++;
        end
        chk("done_if_gap", 32'(cyc - t_dack), 4);
        chk("done_no_double_ack", 32'(extra_d), 0);
        chk("done_if_rdata", o_if_rdata, 32'hC0DE_0003);
        @(posedge clk); #1 if_req = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic from both ports
        if_done = 0; d_done = 0;
        begin
            bit if_act = 0, d_act = 0;
            repeat (3000) begin
                @(posedge clk); #1;
                if (!if_act) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if_act = 1; if_req = 1'b1; if_addr = AW'($urandom_range(0, 15));
                    end
                end else if (if_done) begin
                    if_done = 0;
                    if ($urandom_range(0, 2) == 0) begin
                        if_act = 0; if_req = 1'b0;
                    end else begin
                        if_addr = AW'($urandom_range(0, 15));
                    end
                end
                if (!d_act || d_done) begin
                    d_done = 0;
                    if ($urandom_range(0, 3) == 0) begin
                        d_act = 0; d_req = 1'b0;
                    end else begin
                        d_act = 1; d_req = 1'b1;
                        d_we = 1'($urandom_range(0, 1));
                        d_be = BW'($urandom_range(0, 15));
                        d_addr = AW'($urandom_range(0, 15));
                        d_wdata = $urandom;
                    end
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (10) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
